// File: rtl/pid_pkg.sv
// Shared helpers for the parametrised PID loop: saturation functions and
// the derived width of the P+I+D summing node.
package pid_pkg;

  function automatic int sum_width(input int err_w, input int i_w,
                                   input int d_sat_w, input int d_shift);
    int m;
    m = err_w;
    if (i_w + 1 > m) m = i_w + 1;
    if (d_sat_w + d_shift > m) m = d_sat_w + d_shift;
    return m + 2;
  endfunction

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  // Clamp a signed value into 0 .. 2^w-1.
  function automatic logic [63:0] sat_unsigned(input logic signed [63:0] v,
                                               input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (v < 64'sd0) return '0;
    else if (v > hi) return $unsigned(hi);
    else return $unsigned(v);
  endfunction

endpackage

// File: rtl/pid_decim_timer.sv
// Free-running decimation counter; pulses decim_tick for one cycle after
// each terminal count of the active counter width.
module pid_decim_timer #(
  parameter int DECIM_W  = 20,
  parameter int FAST_SIM = 0,
  parameter int FAST_W   = 15
) (
  input  logic clk,
  input  logic rst_n,
  output logic decim_tick
);

  localparam int CNT_W = (FAST_SIM != 0) ? FAST_W : DECIM_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = &cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign decim_tick = tick_q;

endmodule

// File: rtl/pid_ctrl_param.sv
// Parametrised PID loop: signed error in, saturated unsigned drive magnitude
// out, with decimated integrator and D history and a two-stage output pipe.
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int ERR_W    = 13,
  parameter int OUT_W    = 12,
  parameter int I_W      = 18,
  parameter int DECIM_W  = 20,
  parameter int FAST_SIM = 0,
  parameter int FAST_W   = 15,
  parameter int D_DEPTH  = 3,
  parameter int D_SAT_W  = 9,
  parameter int D_SHIFT  = 1,
  parameter int I_SHIFT  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] error,
  input  logic                    err_vld,
  input  logic                    not_pedaling,
  input  logic                    i_clr,
  output logic [OUT_W-1:0]        drv_mag,
  output logic                    drv_vld,
  output logic                    decim_tick
);

  localparam int SUM_W = sum_width(ERR_W, I_W, D_SAT_W, D_SHIFT);

  logic                                tick;
  logic signed [ERR_W-1:0]             err_q, err_d;
  logic [I_W-1:0]                      integ_q, integ_d;
  logic [D_DEPTH-1:0][ERR_W-1:0]       hist_q, hist_d;
  logic signed [SUM_W-1:0]             sum_q, sum_d;
  logic [OUT_W-1:0]                    drv_mag_q, drv_mag_d;
  logic [2:0]                          vld_pipe_q, vld_pipe_d;

  logic signed [I_W:0]                 i_sum;
  logic signed [ERR_W:0]               d_raw;
  logic signed [D_SAT_W-1:0]           d_sat;
  logic signed [SUM_W-1:0]             p_term, i_term, d_term;

  pid_decim_timer #(
    .DECIM_W  (DECIM_W),
    .FAST_SIM (FAST_SIM),
    .FAST_W   (FAST_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .decim_tick (tick)
  );

  // Integrator clamps to the positive half of its register so it never wraps.
  always_comb begin
    err_d = err_vld ? error : err_q;

    i_sum = (I_W+1)'(err_q) + (I_W+1)'($signed({1'b0, integ_q}));
    if (not_pedaling || i_clr)
      integ_d = '0;
    else if (tick)
      integ_d = I_W'(sat_unsigned(64'(i_sum), I_W - 1));
    else
      integ_d = integ_q;

    hist_d = hist_q;
    if (tick) begin
      hist_d[0] = err_q;
      for (int k = 1; k < D_DEPTH; k++) hist_d[k] = hist_q[k-1];
    end

    d_raw  = (ERR_W+1)'(err_q) - (ERR_W+1)'($signed(hist_q[D_DEPTH-1]));
    d_sat  = D_SAT_W'(sat_signed(64'(d_raw), D_SAT_W));
    p_term = SUM_W'(err_q);
    i_term = SUM_W'($signed({1'b0, integ_q >> I_SHIFT}));
    d_term = SUM_W'(d_sat) <<< D_SHIFT;
    sum_d  = p_term + i_term + d_term;

    drv_mag_d  = OUT_W'(sat_unsigned(64'(sum_q), OUT_W));
    vld_pipe_d = {vld_pipe_q[1:0], tick};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      integ_q    <= '0;
      hist_q     <= '0;
      sum_q      <= '0;
      drv_mag_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      err_q      <= err_d;
      integ_q    <= integ_d;
      hist_q     <= hist_d;
      sum_q      <= sum_d;
      drv_mag_q  <= drv_mag_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign drv_mag    = drv_mag_q;
  assign drv_vld    = vld_pipe_q[2];
  assign decim_tick = tick;

endmodule
